regfile_mp: RTL

Parametrised multi-port register file for the MIPS datapath's decode stage, the successor to the fixed 32x32 two-read-port file. It provides NRD combinational read ports with same-cycle write-through bypass, one write port, optional hardwired-zero register 0, and an asynchronous reset that clears all registers. A sequenced clear sweep lets the debug unit zero the file without a reset. A flattened snapshot bus feeds the debug/UART dump path.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_seq.sv | 92 +++++++++
 rtl/regfile_mp.sv | 103 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file: the clear-sweep
//   state encoding and a helper that locates a port's slice inside the
//   flattened address/data buses.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Lowest bit of port 'port' in a bus packed as port k at [k*width +: width].
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
//   Sequencer for the register-file clear sweep. In IDLE a sampled i_clear
//   starts a sweep that zeroes one register per clock, from 0 up to NREGS-1,
//   then returns to IDLE. Writes arriving while the sweep runs are dropped
//   and reported one cycle later on o_wr_drop.
//
//   Ports
//     clk        in   clock, state updates on posedge
//     i_rst_n    in   asynchronous active-low reset
//     i_clear    in   start request, honoured only in IDLE
//     i_wenable  in   write request from the datapath (for drop reporting)
//     clr_en     out  sweep active: array must write 0 to clr_addr
//     clr_addr   out  register being cleared this cycle
//     o_busy     out  sweep in progress (from the state register)
//     o_wr_drop  out  registered pulse: last cycle's write was discarded
module regfile_clear_seq #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_wenable,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              o_busy,
  output logic              o_wr_drop
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  rf_state_e         state;
  rf_state_e         state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RF_IDLE: begin
        if (i_clear) begin
          state_next = RF_CLEAR;
          cnt_next   = '0;
        end
      end
      RF_CLEAR: begin
        // i_clear is ignored here; the sweep never restarts mid-way.
        if (cnt == LAST_ADDR) begin
          state_next = RF_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_next = RF_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // One pulse per dropped write; stays high while drops continue.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_drop <= 1'b0;
    end else begin
      o_wr_drop <= (state == RF_CLEAR) && i_wenable;
    end
  end

  assign clr_en   = (state == RF_CLEAR);
  assign clr_addr = cnt;
  assign o_busy   = clr_en;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file for the decode stage: NRD combinational read
//   ports with same-cycle write-through bypass, one write port, optional
//   hardwired-zero register 0, a sequenced clear sweep and a flattened
//   snapshot bus for the debug dump path.
//
//   Ports
//     clk          in   clock
//     i_rst_n      in   asynchronous active-low reset, clears every register
//     i_wenable    in   write request
//     i_waddr      in   write address
//     i_wdata      in   write data
//     i_rd_addr    in   read addresses, port k at [k*ADDR_W +: ADDR_W]
//     o_rd_data    out  read data, port k at [k*DATA_W +: DATA_W]
//     i_clear      in   start clear sweep (acted on only when idle)
//     o_busy       out  clear sweep in progress
//     o_wr_drop    out  previous cycle's write was dropped by the sweep
//     o_registers  out  array snapshot, register 0 in the MSBs
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_wenable,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic [NRD*ADDR_W-1:0]   i_rd_addr,
  output logic [NRD*DATA_W-1:0]   o_rd_data,
  input  logic                    i_clear,
  output logic                    o_busy,
  output logic                    o_wr_drop,
  output logic [NREGS*DATA_W-1:0] o_registers
);

  import regfile_pkg::*;

  logic [DATA_W-1:0] regs [NREGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  regfile_clear_seq #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_clear),
    .i_wenable (i_wenable),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .o_busy    (o_busy),
    .o_wr_drop (o_wr_drop)
  );

  // A write to register 0 with ZERO_REG set is swallowed silently, not dropped.
  assign wr_ok = i_wenable && !clr_en && !(ZERO_REG && (i_waddr == '0));

  // NOTE: the array is reset explicitly because reset must leave the file
  // architecturally zero; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_en) begin
      regs[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: hardwired zero beats bypass, bypass beats the array.
  // Bypass is disabled during the sweep since those writes never land.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = i_rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      data = regs[addr];
      if (!clr_en && i_wenable && (i_waddr == addr)) begin
        data = i_wdata;
      end
      if (ZERO_REG && (addr == '0)) begin
        data = '0;
      end
    end

    assign o_rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
  end

  // Snapshot shows array contents only, register 0 in the top slice.
  for (genvar i = 0; i < NREGS; i++) begin : g_snap
    assign o_registers[(NREGS-1-i)*DATA_W +: DATA_W] = regs[i];
  end

endmodule
